// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V main controller: opcodes, FSM states,
// instruction classes and the datapath select fields.
package riscv_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

    // S_RESET is the fetch-pending state held while reset is asserted.
    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_R,
        C_I,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_LUI,
        C_AUIPC,
        C_HALT,
        C_ILLEGAL
    } opclass_t;

    localparam logic [SEL_W-1:0] PCSRC_PLUS4 = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_REL   = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JALR  = 2'b10;

    localparam logic [SEL_W-1:0] WBSEL_ALU = 2'b00;
    localparam logic [SEL_W-1:0] WBSEL_MEM = 2'b01;
    localparam logic [SEL_W-1:0] WBSEL_PC4 = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD    = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT  = 2'b10;

    typedef struct packed {
        logic             ir_write;
        logic             pc_write;
        logic [SEL_W-1:0] pc_src;
        logic             alu_src;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] wb_sel;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             halt;
        logic             trap;
    } ctrl_t;

endpackage

// File: rtl/mc_controller_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
interface mc_controller_if;

    logic [6:0] Opcode;
    logic       BrTaken;
    logic       MemReady;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       ALUSrc;
    logic [1:0] ALUOp;
    logic [1:0] WBSel;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       Branch;
    logic       Halt;
    logic       Trap;

    modport master (
        input  Opcode, BrTaken, MemReady,
        output IRWrite, PCWrite, PCSrc, ALUSrc, ALUOp, WBSel,
               RegWrite, MemRead, MemWrite, Branch, Halt, Trap
    );

    modport slave (
        output Opcode, BrTaken, MemReady,
        input  IRWrite, PCWrite, PCSrc, ALUSrc, ALUOp, WBSel,
               RegWrite, MemRead, MemWrite, Branch, Halt, Trap
    );

endinterface

// File: rtl/op_classifier.sv
// Combinational opcode-to-class decode; the halt opcode wins over every other class.
module op_classifier
    import riscv_pkg::*;
#(
    parameter logic [6:0] HALT_OPCODE = OP_SYSTEM,
    parameter bit         EN_JUMPS    = 1'b1
) (
    input  logic [6:0] opcode,
    output opclass_t   opclass
);

    always_comb begin
        opclass = C_ILLEGAL;
        if (opcode == HALT_OPCODE) begin
            opclass = C_HALT;
        end else begin
            case (opcode)
                OP_R:      opclass = C_R;
                OP_I:      opclass = C_I;
                OP_LOAD:   opclass = C_LOAD;
                OP_STORE:  opclass = C_STORE;
                OP_BRANCH: opclass = C_BRANCH;
                OP_JAL:    opclass = EN_JUMPS ? C_JAL : C_ILLEGAL;
                OP_JALR:   opclass = EN_JUMPS ? C_JALR : C_ILLEGAL;
                OP_LUI:    opclass = C_LUI;
                OP_AUIPC:  opclass = C_AUIPC;
                default:   opclass = C_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle main controller: sequences fetch/decode/exec/mem/writeback, with
// halt, illegal-opcode trap and a bounded wait for data-memory ready.
module mc_controller
    import riscv_pkg::*;
#(
    parameter logic [6:0]  HALT_OPCODE = OP_SYSTEM,
    parameter int unsigned TIMEOUT_W   = 4,
    parameter bit          EN_JUMPS    = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);

    localparam logic [TIMEOUT_W-1:0] WAIT_ONE = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] WAIT_MAX = '1;

    state_t               state;
    state_t               state_next;
    opclass_t             cls;
    opclass_t             cls_next;
    opclass_t             cls_dec;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [TIMEOUT_W-1:0] wait_next;
    logic [TIMEOUT_W-1:0] wait_inc;
    ctrl_t                ctl;

    op_classifier #(
        .HALT_OPCODE (HALT_OPCODE),
        .EN_JUMPS    (EN_JUMPS)
    ) u_classifier (
        .opcode  (bus.Opcode),
        .opclass (cls_dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_RESET;
            cls      <= C_ILLEGAL;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            cls      <= cls_next;
            wait_cnt <= wait_next;
        end
    end

    // Next state, latched class and memory-wait counter.
    always_comb begin
        state_next = state;
        cls_next   = cls;
        wait_next  = wait_cnt;
        wait_inc   = wait_cnt + WAIT_ONE;
        case (state)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                cls_next = cls_dec;
                case (cls_dec)
                    C_HALT:    state_next = S_HALT;
                    C_ILLEGAL: state_next = S_TRAP;
                    default:   state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                wait_next = '0;
                case (cls)
                    C_LOAD, C_STORE: state_next = S_MEM;
                    C_BRANCH:        state_next = S_FETCH;
                    default:         state_next = S_WB;
                endcase
            end
            S_MEM: begin
                // Ready on the cycle the counter would saturate still completes.
                if (bus.MemReady) begin
                    state_next = (cls == C_LOAD) ? S_WB : S_FETCH;
                end else begin
                    wait_next = wait_inc;
                    if (wait_inc == WAIT_MAX) begin
                        state_next = S_TRAP;
                    end
                end
            end
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_RESET;
        endcase
    end

    // Moore decode of state/class; PCWrite on a taken branch is the only Mealy term.
    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.ir_write = 1'b1;
                ctl.pc_write = 1'b1;
                ctl.pc_src   = PCSRC_PLUS4;
            end
            S_EXEC: begin
                case (cls)
                    C_R: begin
                        ctl.alu_op = ALUOP_FUNCT;
                    end
                    C_I: begin
                        ctl.alu_src = 1'b1;
                        ctl.alu_op  = ALUOP_FUNCT;
                    end
                    C_LOAD, C_STORE, C_LUI, C_AUIPC: begin
                        ctl.alu_src = 1'b1;
                        ctl.alu_op  = ALUOP_ADD;
                    end
                    C_BRANCH: begin
                        ctl.branch   = 1'b1;
                        ctl.alu_op   = ALUOP_BRANCH;
                        ctl.pc_src   = PCSRC_REL;
                        ctl.pc_write = bus.BrTaken;
                    end
                    C_JAL: begin
                        ctl.pc_write = 1'b1;
                        ctl.pc_src   = PCSRC_REL;
                    end
                    C_JALR: begin
                        ctl.pc_write = 1'b1;
                        ctl.pc_src   = PCSRC_JALR;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctl.mem_read  = (cls == C_LOAD);
                ctl.mem_write = (cls == C_STORE);
            end
            S_WB: begin
                ctl.reg_write = 1'b1;
                if (cls == C_LOAD) begin
                    ctl.wb_sel = WBSEL_MEM;
                end else if (cls == C_JAL || cls == C_JALR) begin
                    ctl.wb_sel = WBSEL_PC4;
                end else begin
                    ctl.wb_sel = WBSEL_ALU;
                end
            end
            S_HALT:  ctl.halt = 1'b1;
            S_TRAP:  ctl.trap = 1'b1;
            default: ;
        endcase
    end

    assign bus.IRWrite  = ctl.ir_write;
    assign bus.PCWrite  = ctl.pc_write;
    assign bus.PCSrc    = ctl.pc_src;
    assign bus.ALUSrc   = ctl.alu_src;
    assign bus.ALUOp    = ctl.alu_op;
    assign bus.WBSel    = ctl.wb_sel;
    assign bus.RegWrite = ctl.reg_write;
    assign bus.MemRead  = ctl.mem_read;
    assign bus.MemWrite = ctl.mem_write;
    assign bus.Branch   = ctl.branch;
    assign bus.Halt     = ctl.halt;
    assign bus.Trap     = ctl.trap;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-cycle control vectors compared against a sequence
// model built from instruction-class rules. u_nj has jumps disabled and a 2-bit timer.
module tb_mc_controller;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_HALT   = 7'b1110011;
    localparam int NEVER = 1000;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       halt;
        logic       trap;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;
    ctl_t       obs1, obs2;
    ctl_t       exp_q[$];
    ctl_t       obs_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    mc_controller_if bus1();
    mc_controller_if bus2();

    assign bus1.Opcode = opcode;   assign bus2.Opcode = opcode;
    assign bus1.BrTaken = br_taken; assign bus2.BrTaken = br_taken;
    assign bus1.MemReady = mem_ready; assign bus2.MemReady = mem_ready;

    assign obs1 = {bus1.IRWrite, bus1.PCWrite, bus1.PCSrc, bus1.ALUSrc, bus1.ALUOp, bus1.WBSel,
                   bus1.RegWrite, bus1.MemRead, bus1.MemWrite, bus1.Branch, bus1.Halt, bus1.Trap};
    assign obs2 = {bus2.IRWrite, bus2.PCWrite, bus2.PCSrc, bus2.ALUSrc, bus2.ALUOp, bus2.WBSel,
                   bus2.RegWrite, bus2.MemRead, bus2.MemWrite, bus2.Branch, bus2.Halt, bus2.Trap};

    mc_controller u_dut (.clk(clk), .reset(reset), .bus(bus1));
    mc_controller #(.EN_JUMPS(1'b0), .TIMEOUT_W(2)) u_nj (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    function automatic ctl_t wb_vec(input logic [1:0] sel);
        ctl_t v;
        v = '0; v.reg_write = 1'b1; v.wb_sel = sel;
        return v;
    endfunction

    // Expected per-cycle vectors for one instruction starting at its FETCH cycle.
    function automatic void build(input logic [6:0] opc, input bit br, input int w,
                                  input bit en_j, input int tw, input int park);
        ctl_t z, v, t;
        int mem_max;
        z = '0; t = '0; t.trap = 1'b1;
        mem_max = (1 << tw) - 1;
        exp_q.delete();
        v = z; v.ir_write = 1'b1; v.pc_write = 1'b1; exp_q.push_back(v);
        exp_q.push_back(z);
        case (opc)
            OP_R: begin
                v = z; v.alu_op = 2'b10; exp_q.push_back(v); exp_q.push_back(wb_vec(2'b00));
            end
            OP_I: begin
                v = z; v.alu_op = 2'b10; v.alu_src = 1'b1;
                exp_q.push_back(v); exp_q.push_back(wb_vec(2'b00));
            end
            OP_LUI, OP_AUIPC: begin
                v = z; v.alu_src = 1'b1; exp_q.push_back(v); exp_q.push_back(wb_vec(2'b00));
            end
            OP_BRANCH: begin
                v = z; v.branch = 1'b1; v.alu_op = 2'b01; v.pc_src = 2'b01; v.pc_write = br;
                exp_q.push_back(v);
            end
            OP_JAL, OP_JALR: begin
                if (en_j) begin
                    v = z; v.pc_write = 1'b1; v.pc_src = (opc == OP_JAL) ? 2'b01 : 2'b10;
                    exp_q.push_back(v); exp_q.push_back(wb_vec(2'b10));
                end else begin
                    repeat (park) exp_q.push_back(t);
                end
            end
            OP_LOAD, OP_STORE: begin
                v = z; v.alu_src = 1'b1; exp_q.push_back(v);
                v = z; v.mem_read = (opc == OP_LOAD); v.mem_write = (opc == OP_STORE);
                if (w < mem_max) begin
                    repeat (w + 1) exp_q.push_back(v);
                    if (opc == OP_LOAD) exp_q.push_back(wb_vec(2'b01));
                end else begin
                    repeat (mem_max) exp_q.push_back(v);
                    repeat (park) exp_q.push_back(t);
                end
            end
            OP_HALT: begin
                v = z; v.halt = 1'b1; repeat (park) exp_q.push_back(v);
            end
            default: repeat (park) exp_q.push_back(t);
        endcase
    endfunction

    // Drive one instruction for exp_q.size() cycles and record the chosen DUT's outputs.
    task automatic drive(input logic [6:0] opc, input bit br, input int w, input bit use2);
        bit mem_op;
        mem_op = (opc == OP_LOAD || opc == OP_STORE);
        obs_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            opcode   = (i == 0) ? 7'($urandom) : opc;
            br_taken = (i == 2) ? br : 1'($urandom);
            if (mem_op && i >= 3 && i <= 3 + w) mem_ready = (i == 3 + w);
            else mem_ready = 1'($urandom);
            @(negedge clk);
            obs_q.push_back(use2 ? obs2 : obs1);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk); reset = 1'b1;
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        ctl_t f;
        f = '0; f.ir_write = 1'b1; f.pc_write = 1'b1;
        reset = 1'b1; mem_ready = 1'b1; br_taken = 1'b1;
        repeat (2) begin
            @(negedge clk); opcode = 7'($urandom);
            n_cmp++; if (obs1 !== ctl_t'(0)) begin n_bad++; $display("FAIL reset_main got %h want 0", obs1); end
            n_cmp++; if (obs2 !== ctl_t'(0)) begin n_bad++; $display("FAIL reset_nj got %h want 0", obs2); end
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (obs1 !== ctl_t'(0)) begin n_bad++; $display("FAIL reset_pending got %h want 0", obs1); end
        @(negedge clk);
        n_cmp++; if (obs1 !== f) begin n_bad++; $display("FAIL reset_first_fetch got %h want %h", obs1, f); end
    endtask

    task automatic test_alu();
        logic [6:0] ops [4];
        ops = '{OP_R, OP_I, OP_LUI, OP_AUIPC};
        apply_reset();
        foreach (ops[k]) begin
            build(ops[k], 1'b0, 0, 1'b1, 4, 0);
            drive(ops[k], 1'b0, 0, 1'b0);
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL alu op=%b cyc %0d got %h want %h", ops[k], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_load();
        int ws [3];
        ws = '{2, 0, 14};
        apply_reset();
        foreach (ws[k]) begin
            build(OP_LOAD, 1'b0, ws[k], 1'b1, 4, 0);
            drive(OP_LOAD, 1'b0, ws[k], 1'b0);
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL load w=%0d cyc %0d got %h want %h", ws[k], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_branch();
        apply_reset();
        for (int b = 1; b >= 0; b--) begin
            build(OP_BRANCH, 1'(b), 0, 1'b1, 4, 0);
            drive(OP_BRANCH, 1'(b), 0, 1'b0);
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL branch taken=%0d cyc %0d got %h want %h", b, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_jumps();
        logic [6:0] ops [2];
        ops = '{OP_JALR, OP_JAL};
        apply_reset();
        foreach (ops[k]) begin
            build(ops[k], 1'b0, 0, 1'b1, 4, 0);
            drive(ops[k], 1'b0, 0, 1'b0);
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL jump op=%b cyc %0d got %h want %h", ops[k], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_store_timeout();
        int ws [2];
        ctl_t f;
        ws = '{14, NEVER};
        f = '0; f.ir_write = 1'b1; f.pc_write = 1'b1;
        apply_reset();
        foreach (ws[k]) begin
            build(OP_STORE, 1'b0, ws[k], 1'b1, 4, 5);
            drive(OP_STORE, 1'b0, ws[k], 1'b0);
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL store w=%0d cyc %0d got %h want %h", ws[k], i, obs_q[i], exp_q[i]);
                end
            end
        end
        @(negedge clk); reset = 1'b1; #1;
        n_cmp++; if (obs1 !== ctl_t'(0)) begin n_bad++; $display("FAIL trap_clear got %h want 0", obs1); end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (obs1 !== f) begin n_bad++; $display("FAIL fetch_after_trap got %h want %h", obs1, f); end
    endtask

    task automatic test_halt_trap();
        logic [6:0] ops [3];
        ops = '{OP_HALT, 7'b0000000, 7'b1111111};
        foreach (ops[k]) begin
            apply_reset();
            build(ops[k], 1'b0, 0, 1'b1, 4, 20);
            drive(ops[k], 1'b0, 0, 1'b0);
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL park op=%b cyc %0d got %h want %h", ops[k], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_abort();
        ctl_t m, f;
        m = '0; m.mem_write = 1'b1;
        f = '0; f.ir_write = 1'b1; f.pc_write = 1'b1;
        apply_reset();
        @(posedge clk); #1 opcode = OP_STORE; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (obs1 !== m) begin n_bad++; $display("FAIL abort_in_mem got %h want %h", obs1, m); end
        #2 reset = 1'b1; #1;
        n_cmp++; if (obs1 !== ctl_t'(0)) begin n_bad++; $display("FAIL abort_outputs got %h want 0", obs1); end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (obs1 !== f) begin n_bad++; $display("FAIL abort_refetch got %h want %h", obs1, f); end
    endtask

    task automatic test_no_jumps();
        logic [6:0] ops [6];
        int ws [6];
        ops = '{OP_JALR, OP_JAL, OP_R, OP_STORE, OP_LOAD, OP_BRANCH};
        ws  = '{0, 0, 0, NEVER, 2, 0};
        foreach (ops[k]) begin
            if (k < 3 || k == 4) apply_reset();
            build(ops[k], 1'b1, ws[k], 1'b0, 2, 5);
            drive(ops[k], 1'b1, ws[k], 1'b1);
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL nojump op=%b cyc %0d got %h want %h", ops[k], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] pool [9];
        logic [6:0] opc;
        bit br;
        int w;
        pool = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            opc = pool[$urandom_range(0, 8)];
            br  = 1'($urandom);
            w   = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 4));
            build(opc, br, w, 1'b1, 4, 0);
            drive(opc, br, w, 1'b0);
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL b2b #%0d op=%b w=%0d cyc %0d got %h want %h", n, opc, w, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_jumps();
        test_store_timeout();
        test_halt_trap();
        test_abort();
        test_no_jumps();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle successor to the single-cycle main control decoder: an FSM that sequences each RISC-V instruction through fetch, decode, execute, memory and writeback cycles. It drives the shared-ALU/shared-PC datapath. It adds jump, LUI/AUIPC, halt and illegal-opcode trap handling, plus a data-memory ready handshake with timeout. It sits beside the existing ALU controller, which still consumes `ALUOp`.

## Interface
- `HALT_OPCODE`, default 7'b1110011: opcode that parks the core in HALT.
- `TIMEOUT_W`, default 4: width of the memory-wait counter; timeout after 2^TIMEOUT_W − 1 wait cycles.
- `EN_JUMPS`, default 1: 0 makes JAL/JALR illegal (trap).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `Opcode`  in  7  instruction[6:0] from IR; stable from DECODE until the next FETCH.
- `BrTaken`  in  1  ALU branch-condition result, valid in EXEC.
- `MemReady`  in  1  data memory has completed the current access.
- `IRWrite`  out  1  load IR.
- `PCWrite`  out  1  update PC.
- `PCSrc`  out  2  00 PC+4, 01 PC-relative target (branch/JAL), 10 JALR target.
- `ALUSrc`  out  1  0 register, 1 immediate.
- `ALUOp`  out  2  00 add (addr/LUI/AUIPC), 01 branch compare, 10 R/I decode.
- `WBSel`  out  2  00 ALU, 01 memory, 10 PC+4.
- `RegWrite`, `MemRead`, `MemWrite`, `Branch`  out  1 each  as named.
- `Halt`, `Trap`  out  1 each  sticky status.

## Operation
- Opcode classes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, HALT_OPCODE. Any other opcode is ILLEGAL.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- FETCH: `IRWrite`=1, `PCWrite`=1, `PCSrc`=00. Next state is DECODE.
- DECODE: classify `Opcode` and register the class. HALT goes to HALT, ILLEGAL goes to TRAP, all others go to EXEC.
- EXEC, per class:
  - R/I: `ALUOp`=10; `ALUSrc`=1 for I only. Next WB.
  - LOAD/STORE: `ALUSrc`=1, `ALUOp`=00. Next MEM.
  - LUI/AUIPC: `ALUSrc`=1, `ALUOp`=00. Next WB.
  - BRANCH: `Branch`=1, `ALUOp`=01, `PCSrc`=01, `PCWrite`=`BrTaken` (combinational). Next FETCH.
  - JAL/JALR: `PCWrite`=1, `PCSrc`=01 (JAL) or 10 (JALR). Next WB.
- MEM:
  - Holds `MemRead` (LOAD) or `MemWrite` (STORE) continuously until `MemReady`.
  - On `MemReady`: STORE goes to FETCH, LOAD goes to WB.
  - Wait counter clears on MEM entry and increments each cycle without `MemReady`.
  - At all-ones without `MemReady`, the counter goes to TRAP and drops `MemRead`/`MemWrite` the next cycle.
  - `MemReady` on the same cycle the counter saturates counts as success.
- WB: `RegWrite`=1. `WBSel` is 01 for LOAD, 10 for JAL/JALR, 00 otherwise. Next FETCH.
- HALT/TRAP: absorbing, with `Halt`/`Trap`=1. All enables are 0. Only `reset` exits.
- Every output not listed as active in a state is 0.

## Timing
- While `reset`=1, state is FETCH-pending and all outputs are 0, including `IRWrite`. The first FETCH is the first cycle after deassertion.
- Reset asserted mid-instruction aborts it immediately (asynchronous), with no write enables in that cycle.
- Outputs are Moore-decoded from the registered state and class. The only Mealy term is `PCWrite` in EXEC/BRANCH.
- Cycle counts:
  - BRANCH: 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - STORE: 4+w cycles; LOAD: 5+w cycles, where w is the number of MEM cycles without `MemReady`.
- `MemReady` outside MEM is ignored.
- Wait counter width is `TIMEOUT_W`. It never wraps; TRAP is taken instead.

## Structure
- `riscv_pkg`: opcode constants, the `state_t` enum, the `opclass_t` enum, and the `PCSrc`/`WBSel`/`ALUOp` encodings.
- Sub-module `op_classifier`: combinational Opcode→`opclass_t`, parameterised by `HALT_OPCODE` and `EN_JUMPS`.
- Top `mc_controller`: state register, class register, wait counter and output decode.

## Test plan
- `add` (0110011): states F,D,E,W over 4 cycles; `RegWrite`=1 only in cycle 4 with `WBSel`=00 and `ALUOp`=10 in EXEC.
- `lw` with `MemReady` after 2 wait cycles: `MemRead` high 3 cycles, then WB with `WBSel`=01; 7 cycles total.
- `beq` with `BrTaken`=1, then with 0: `PCWrite` in EXEC is 1 and `PCSrc`=01 in the first case, `PCWrite`=0 in the second; both return to FETCH after 3 cycles.
- `jalr` (1100111): EXEC gives `PCWrite`=1 and `PCSrc`=10; WB gives `RegWrite`=1 and `WBSel`=10. With `EN_JUMPS`=0, the same opcode gives TRAP after DECODE.
- `sw` with `MemReady` never asserted, `TIMEOUT_W`=4: `MemWrite` held 15 cycles, then `Trap`=1 sticky. Asserting `reset` clears it, and the next FETCH is asserted one cycle after deassertion.
- Opcode 1110011: `Halt`=1 from the cycle after DECODE. Opcode 0000000 gives `Trap`=1. Both persist for 20 cycles with every enable at 0.
